// File: rtl/vproc_pkg.sv
// Shared types for the vector processor: RAM implementation selector and
// the register-file initialisation FSM states.
package vproc_pkg;

    typedef enum logic [1:0] {
        RAM_GENERIC,
        RAM_XLNX_RAM32M,
        RAM_ASIC_MACRO
    } ram_type;

    typedef enum logic {
        VREG_INIT_IDLE,
        VREG_INIT_SWEEP
    } vreg_init_state_e;

endpackage

// File: rtl/vproc_vregfile_xmp_row.sv
// One XOR row: RD_PORTS identical RAM copies sharing a byte-enabled write
// port and a full-word clear port, each copy serving one asynchronous read.
module vproc_vregfile_xmp_row #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PORT_W   = 128,
    parameter int unsigned RD_PORTS = 3
) (
    input  logic                clk_i,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PORT_W-1:0]   wr_data,
    input  logic [PORT_W/8-1:0] wr_be,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic [ADDR_W-1:0]   rd_addr [RD_PORTS],
    output logic [PORT_W-1:0]   rd_data [RD_PORTS]
);

    for (genvar c = 0; c < RD_PORTS; c++) begin : g_copy
        logic [PORT_W-1:0] mem [DEPTH];

        // NOTE: the array has no reset; zeroing is done by the clear-write sweep.
        always_ff @(posedge clk_i) begin
            if (clr) begin
                mem[clr_addr] <= '0;
            end else if (we) begin
                for (int b = 0; b < PORT_W/8; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end

        assign rd_data[c] = mem[rd_addr[c]];
    end

endmodule

// File: rtl/vproc_vregfile_xmp.sv
// XOR-based multi-ported vector register file with write-conflict masking,
// optional write-to-read bypass, optional output register and a zeroing sweep.
module vproc_vregfile_xmp import vproc_pkg::*; #(
    parameter int unsigned VREG_W   = 128,
    parameter int unsigned PORT_W   = 128,
    parameter int unsigned VREG_CNT = 32,
    parameter int unsigned PORTS_RD = 2,
    parameter int unsigned PORTS_WR = 2,
    parameter int unsigned RD_LAT   = 0,
    parameter bit          BYPASS   = 1'b1,
    parameter ram_type     RAM_TYPE = RAM_GENERIC,
    localparam int unsigned WPR     = VREG_W / PORT_W,
    localparam int unsigned DEPTH   = VREG_CNT * WPR,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned NB      = PORT_W / 8
) (
    input  logic                clk_i,
    input  logic                async_rst_ni,
    input  logic [ADDR_W-1:0]   wr_addr_i     [PORTS_WR],
    input  logic [PORT_W-1:0]   wr_data_i     [PORTS_WR],
    input  logic [NB-1:0]       wr_be_i       [PORTS_WR],
    input  logic                wr_we_i       [PORTS_WR],
    input  logic [ADDR_W-1:0]   rd_addr_i     [PORTS_RD],
    output logic [PORT_W-1:0]   rd_data_o     [PORTS_RD],
    input  logic                init_req_i,
    output logic                init_busy_o,
    output logic [PORTS_WR-1:0] wr_conflict_o
);

    localparam int unsigned RPR = PORTS_RD + PORTS_WR - 1;

    if (RAM_TYPE != RAM_GENERIC) begin : g_bad_ram
        $error("vproc_vregfile_xmp: only RAM_GENERIC is supported");
    end
    if (RD_LAT > 1) begin : g_bad_lat
        $error("vproc_vregfile_xmp: RD_LAT must be 0 or 1");
    end
    if (VREG_W % PORT_W != 0) begin : g_bad_width
        $error("vproc_vregfile_xmp: VREG_W must be a multiple of PORT_W");
    end

    // Row x reserves read slots after the external ones for every other write port y.
    function automatic int unsigned slot(int unsigned x, int unsigned y);
        return PORTS_RD + ((y < x) ? y : y - 1);
    endfunction

    vreg_init_state_e  state_q;
    logic [ADDR_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments; always_comb logic uses blocking.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= VREG_INIT_SWEEP;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                VREG_INIT_IDLE: begin
                    if (init_req_i) begin
                        state_q <= VREG_INIT_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                VREG_INIT_SWEEP: begin
                    if (init_req_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= VREG_INIT_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= VREG_INIT_SWEEP;
            endcase
        end
    end

    assign init_busy_o = (state_q == VREG_INIT_SWEEP);

    logic [PORTS_WR-1:0] we_eff;
    logic [PORTS_WR-1:0] conflict_d;
    logic [NB-1:0]       taken    [PORTS_WR];
    logic [NB-1:0]       be_m     [PORTS_WR];
    logic [PORT_W-1:0]   wr_comp  [PORTS_WR];
    logic [ADDR_W-1:0]   row_rd_addr [PORTS_WR][RPR];
    logic [PORT_W-1:0]   row_rd_data [PORTS_WR][RPR];
    logic [PORT_W-1:0]   rd_comb  [PORTS_RD];

    // Lower-indexed write ports win every byte they enable at a shared address.
    always_comb begin
        // NOTE: every output is assigned a default first so no latch is inferred.
        we_eff     = '0;
        conflict_d = '0;
        for (int z = 0; z < PORTS_WR; z++) begin
            taken[z] = '0;
            be_m[z]  = '0;
        end
        for (int z = 0; z < PORTS_WR; z++) begin
            we_eff[z] = wr_we_i[z] & ~init_busy_o;
            for (int y = 0; y < z; y++) begin
                if (wr_we_i[y] && wr_addr_i[y] == wr_addr_i[z]) begin
                    taken[z] = taken[z] | wr_be_i[y];
                end
            end
            if (we_eff[z]) begin
                be_m[z]       = wr_be_i[z] & ~taken[z];
                conflict_d[z] = |(wr_be_i[z] & taken[z]);
            end
        end
    end

    always_comb begin
        for (int x = 0; x < PORTS_WR; x++) begin
            for (int r = 0; r < RPR; r++) begin
                row_rd_addr[x][r] = '0;
            end
            for (int r = 0; r < PORTS_RD; r++) begin
                row_rd_addr[x][r] = rd_addr_i[r];
            end
            for (int y = 0; y < PORTS_WR; y++) begin
                if (y != x) begin
                    row_rd_addr[x][slot(x, y)] = wr_addr_i[y];
                end
            end
        end
    end

    // Row y stores the data XOR the other rows so the XOR over all rows yields the data.
    always_comb begin
        for (int y = 0; y < PORTS_WR; y++) begin
            wr_comp[y] = wr_data_i[y];
            for (int x = 0; x < PORTS_WR; x++) begin
                if (x != y) begin
                    wr_comp[y] = wr_comp[y] ^ row_rd_data[x][slot(x, y)];
                end
            end
        end
    end

    for (genvar x = 0; x < PORTS_WR; x++) begin : g_row
        vproc_vregfile_xmp_row #(
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .PORT_W   (PORT_W),
            .RD_PORTS (RPR)
        ) u_row (
            .clk_i    (clk_i),
            .we       (we_eff[x]),
            .wr_addr  (wr_addr_i[x]),
            .wr_data  (wr_comp[x]),
            .wr_be    (be_m[x]),
            .clr      (init_busy_o),
            .clr_addr (cnt_q),
            .rd_addr  (row_rd_addr[x]),
            .rd_data  (row_rd_data[x])
        );
    end

    always_comb begin
        for (int r = 0; r < PORTS_RD; r++) begin
            rd_comb[r] = '0;
            for (int x = 0; x < PORTS_WR; x++) begin
                rd_comb[r] = rd_comb[r] ^ row_rd_data[x][r];
            end
            if (BYPASS) begin
                for (int y = 0; y < PORTS_WR; y++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be_m[y][b] && wr_addr_i[y] == rd_addr_i[r]) begin
                            rd_comb[r][8*b +: 8] = wr_data_i[y][8*b +: 8];
                        end
                    end
                end
            end
            if (init_busy_o) begin
                rd_comb[r] = '0;
            end
        end
    end

    if (RD_LAT == 1) begin : g_rd_reg
        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                for (int r = 0; r < PORTS_RD; r++) rd_data_o[r] <= '0;
            end else begin
                for (int r = 0; r < PORTS_RD; r++) rd_data_o[r] <= rd_comb[r];
            end
        end
    end else begin : g_rd_comb
        always_comb begin
            for (int r = 0; r < PORTS_RD; r++) rd_data_o[r] = rd_comb[r];
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            wr_conflict_o <= '0;
        end else begin
            wr_conflict_o <= conflict_d;
        end
    end

endmodule

// File: doc/vproc_vregfile_xmp.md
Name: vproc_vregfile_xmp

Overview:
Parametrised XOR-based multi-ported vector register file, next generation of the vector processor register file. Provides PORTS_RD read ports and PORTS_WR write ports over VREG_CNT registers, each split into VREG_W/PORT_W port-sized words. Adds the following over the current file:
- configurable read latency;
- same-cycle write-to-read bypass;
- deterministic resolution of write-write address conflicts;
- a post-reset / on-demand zero-initialisation sequencer, so reads never return undefined XOR residue.

Parameters:
VREG_W, 128, vector register width in bits
PORT_W, 128, port width in bits; VREG_W must be a multiple of PORT_W
VREG_CNT, 32, number of vector registers; power of two, >= 2
PORTS_RD, 2, number of external read ports, >= 1
PORTS_WR, 2, number of write ports, >= 1
RD_LAT, 0, read latency in cycles; only 0 and 1 are legal
BYPASS, 1, 1 = reads see the same cycle's writes
RAM_TYPE, vproc_pkg::RAM_GENERIC, only RAM_GENERIC is legal; any other value is an elaboration error

Derived:
- WPR = VREG_W/PORT_W
- DEPTH = VREG_CNT*WPR
- ADDR_W = $clog2(DEPTH)

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous active-low reset
wr_addr_i[PORTS_WR]  in  ADDR_W  write word address
wr_data_i[PORTS_WR]  in  PORT_W  write data
wr_be_i[PORTS_WR]  in  PORT_W/8  byte enables
wr_we_i[PORTS_WR]  in  1  write enable
rd_addr_i[PORTS_RD]  in  ADDR_W  read word address
rd_data_o[PORTS_RD]  out  PORT_W  read data
init_req_i  in  1  request re-zeroing of the whole file
init_busy_o  out  1  initialisation sweep in progress
wr_conflict_o  out  PORTS_WR  per port: bytes were dropped due to conflict (registered)

Behaviour:
Storage:
- One row of PORTS_RD+PORTS_WR-1 RAM copies per write port, each RAM DEPTH x PORT_W.
- Stored word = XOR of all rows at that address.
- Effective write data for port y = wr_data_i[y] XOR (other rows' values at wr_addr_i[y]), read combinationally through the internal read ports.

Init FSM:
- States IDLE and SWEEP. Reset enters SWEEP with counter = 0.
- SWEEP: each cycle, writes '0 into every RAM of every row at address counter; counter increments by 1. At DEPTH-1 it transitions to IDLE.
- The sweep takes exactly DEPTH cycles after reset deassertion.
- init_req_i in IDLE: go to SWEEP with counter = 0 on the next edge.
- init_req_i during SWEEP: restart the sweep at 0.
- init_busy_o = (state == SWEEP). Reset value is 1.
- During SWEEP all external writes are ignored and every rd_data_o reads '0. These are not conflicts, so wr_conflict_o is not asserted.
- Reset asserted mid-sweep: the sweep restarts from 0 after release.

Write conflicts:
- Ports y < z, both we, equal address: the bytes of z that overlap enabled bytes of y are masked off before the XOR-compose. The lower index wins per byte.
- wr_conflict_o[z] is 1 in the cycle after any such masking, otherwise 0. Reset value is 0.
- Non-overlapping bytes of z are written normally.

Read semantics (M(a) = stored word at the start of the cycle):
- BYPASS=0: comb value = M(rd_addr).
- BYPASS=1: for each byte, take the enabled post-mask write byte if a write port targets rd_addr; otherwise M(rd_addr). This is unique after masking.
- RD_LAT=0: rd_data_o = comb value, same cycle.
- RD_LAT=1: rd_data_o is the comb value registered, visible the next cycle. Reset value is '0. The register loads '0 while busy.

Decomposition:
- vproc_pkg: add vreg_init_state_e {VREG_INIT_IDLE, VREG_INIT_SWEEP}. Reuse the existing ram_type.
- Sub-module vproc_vregfile_xmp_row: one write port, PORTS_RD+PORTS_WR-1 asynchronous read ports, byte enables, and a clear-write input.
- The top level owns the FSM, conflict masking, XOR compose and decompose, bypass and the output register.

Test Plan:
1. Reset release, defaults (DEPTH=32) -> init_busy_o high for exactly 32 cycles; all reads '0 during and after the sweep.
2. After init, WP0 writes addr 5 = 0xA5..A5, all bytes; next cycle RP0 reads addr 5 -> 0xA5..A5 (RD_LAT=0); with RD_LAT=1 the value appears one cycle later.
3. WP0 and WP1 write addr 3 in the same cycle, be 0x000F vs 0x00FF, data 0x11.. vs 0x22.. -> bytes 0-3 = 0x11, bytes 4-7 = 0x22, rest unchanged; wr_conflict_o = 2'b10 for one cycle.
4. BYPASS=1: WP1 writes addr 7 with be 0x0001, data byte 0x3C, while RP1 reads addr 7 in the same cycle -> byte 0 = 0x3C, other bytes old value. With BYPASS=0 -> old value.
5. Both ports write 0xFF.. to addrs 9 and 10; init_req_i pulses at sweep count 4; then further writes issued -> sweep restarts, busy lasts 32 more cycles, writes during busy dropped, addrs 9 and 10 read 0.
6. async_rst_ni asserted mid-sweep (count 17) -> outputs return to reset values immediately; a full 32-cycle sweep follows release.
